// File: rtl/vid_stream_rx_meas.sv
// Receive-side analyzer for a de/hs/vs pixel stream: measures per-frame width,
// height and channel checksum, counts frames and flags line-length / stray-de faults.
module vid_stream_rx_meas #(
  parameter int PIXEL_WIDTH = 8,
  parameter int CH_COUNT    = 3,
  parameter int CNT_WIDTH   = 13,
  parameter int SUM_WIDTH   = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PIXEL_WIDTH*CH_COUNT-1:0] di_i,
  input  logic                            de_i,
  input  logic                            hs_i,
  input  logic                            vs_i,
  output logic [CNT_WIDTH-1:0]            width_o,
  output logic [CNT_WIDTH-1:0]            height_o,
  output logic [SUM_WIDTH-1:0]            sum_o,
  output logic [15:0]                     frame_cnt_o,
  output logic                            err_line_o,
  output logic                            err_de_o,
  output logic                            done_o
);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_hs_d;
  logic [CNT_WIDTH-1:0]   r_pix_cnt;
  logic [CNT_WIDTH-1:0]   r_line_cnt;
  logic [CNT_WIDTH-1:0]   r_first_w;
  logic                   r_first_seen;
  logic [SUM_WIDTH-1:0]   r_sum_acc;
  logic                   r_err_line_acc;
  logic                   r_err_de_acc;

  logic                   w_active;
  logic                   w_frame_open;
  logic                   w_accept;
  logic                   w_de_err;
  logic                   w_line_close;
  logic                   w_line_counted;
  logic                   w_frame_close;
  logic [CNT_WIDTH-1:0]   w_pix_cnt_nxt;
  logic [CNT_WIDTH-1:0]   w_line_cnt_nxt;
  logic [CNT_WIDTH-1:0]   w_first_w_nxt;
  logic                   w_first_seen_nxt;
  logic [SUM_WIDTH-1:0]   w_sum_nxt;
  logic                   w_err_line_nxt;
  logic                   w_err_de_nxt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  function automatic logic [SUM_WIDTH-1:0] chan_sum(input logic [PIXEL_WIDTH*CH_COUNT-1:0] d);
    logic [SUM_WIDTH-1:0] s;
    s = '0;
    for (int c = 0; c < CH_COUNT; c++) begin
      s = s + SUM_WIDTH'(d[c*PIXEL_WIDTH +: PIXEL_WIDTH]);
    end
    return s;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SYNC:   if (!vs_i) w_state_nxt = ST_VBLANK;
      ST_VBLANK: if (vs_i)  w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (!vs_i) w_state_nxt = ST_VBLANK;
      default:   w_state_nxt = ST_SYNC;
    endcase
  end

  assign w_active      = (r_state == ST_ACTIVE);
  assign w_frame_open  = (r_state == ST_VBLANK) & vs_i;
  assign w_accept      = w_active & de_i & ~hs_i & vs_i;
  assign w_de_err      = w_active & de_i & (hs_i | ~vs_i);
  assign w_frame_close = w_active & ~vs_i;

  // A line ends on an hs rise, or when vs drops while the line is still open;
  // both cases fold into "hs was low last cycle and the line is now over".
  assign w_line_close   = w_active & ~r_hs_d & (hs_i | ~vs_i);
  assign w_line_counted = w_line_close & (r_pix_cnt != '0);

  assign w_line_cnt_nxt   = w_line_counted ? sat_inc(r_line_cnt) : r_line_cnt;
  assign w_first_w_nxt    = (w_line_counted & ~r_first_seen) ? r_pix_cnt : r_first_w;
  assign w_first_seen_nxt = r_first_seen | w_line_counted;
  assign w_err_line_nxt   = r_err_line_acc |
                            (w_line_counted & r_first_seen & (r_pix_cnt != r_first_w));
  assign w_err_de_nxt     = r_err_de_acc | w_de_err;
  assign w_pix_cnt_nxt    = w_line_close ? '0 :
                            (w_accept ? sat_inc(r_pix_cnt) : r_pix_cnt);
  assign w_sum_nxt        = w_accept ? r_sum_acc + chan_sum(di_i) : r_sum_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_SYNC;
      r_hs_d         <= 1'b1;
      r_pix_cnt      <= '0;
      r_line_cnt     <= '0;
      r_first_w      <= '0;
      r_first_seen   <= 1'b0;
      r_sum_acc      <= '0;
      r_err_line_acc <= 1'b0;
      r_err_de_acc   <= 1'b0;
      width_o        <= '0;
      height_o       <= '0;
      sum_o          <= '0;
      frame_cnt_o    <= '0;
      err_line_o     <= 1'b0;
      err_de_o       <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hs_d  <= hs_i;
      done_o  <= 1'b0;

      if (w_frame_open) begin
        r_pix_cnt      <= '0;
        r_line_cnt     <= '0;
        r_first_w      <= '0;
        r_first_seen   <= 1'b0;
        r_sum_acc      <= '0;
        r_err_line_acc <= 1'b0;
        r_err_de_acc   <= 1'b0;
      end else if (w_active) begin
        r_pix_cnt      <= w_pix_cnt_nxt;
        r_line_cnt     <= w_line_cnt_nxt;
        r_first_w      <= w_first_w_nxt;
        r_first_seen   <= w_first_seen_nxt;
        r_sum_acc      <= w_sum_nxt;
        r_err_line_acc <= w_err_line_nxt;
        r_err_de_acc   <= w_err_de_nxt;
      end

      // Publish using the post-line-close values so a line ending on the
      // vs fall is still included in the reported geometry.
      if (w_frame_close) begin
        width_o     <= w_first_w_nxt;
        height_o    <= w_line_cnt_nxt;
        sum_o       <= w_sum_nxt;
        err_line_o  <= w_err_line_nxt;
        err_de_o    <= w_err_de_nxt;
        frame_cnt_o <= frame_cnt_o + 16'd1;
        done_o      <= 1'b1;
      end
    end
  end

endmodule
